// File: rtl/id_stage_ctrl.sv
// Decode-stage controller: one-entry output register, load-use scoreboard, trap hold.
// Optional macro WB_FORWARD_EN lets a same-cycle load writeback clear the hazard.
module id_stage_ctrl #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_valid_i,
    output logic             if_ready_o,
    input  logic [XLEN-1:0]  instr_i,
    input  logic [XLEN-1:0]  pc_i,
    input  logic [4:0]       dec_rs1_i,
    input  logic [4:0]       dec_rs2_i,
    input  logic [4:0]       dec_rd_i,
    input  logic             dec_invalid_i,
    output logic             ex_valid_o,
    input  logic             ex_ready_i,
    output logic [XLEN-1:0]  instr_o,
    output logic [XLEN-1:0]  pc_o,
    output logic [4:0]       rd_o,
    input  logic             wb_valid_i,
    input  logic [4:0]       wb_rd_i,
    input  logic             flush_i,
    output logic             trap_o,
    output logic [XLEN-1:0]  trap_pc_o,
    input  logic             trap_ack_i,
    output logic [CNT_W-1:0] stall_cnt_o
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_TRAP = 1'b1
    } state_e;

    localparam logic [6:0] OPC_LOAD = 7'b0000011;

    state_e           state_q, state_d;
    logic             ex_valid_q, ex_valid_d;
    logic [XLEN-1:0]  instr_q, instr_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [4:0]       rd_q, rd_d;
    logic [XLEN-1:0]  trap_pc_q, trap_pc_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [NREGS-1:1] pend_q, pend_d;

    logic [NREGS-1:1] pend_eff;
    logic             rs1_haz, rs2_haz, hazard;
    logic             accept;
    logic             load_set;

    // Pending view used for the hazard check; x0 has no bit and never stalls.
    always_comb begin
        pend_eff = pend_q;
`ifdef WB_FORWARD_EN
        for (int unsigned r = 1; r < NREGS; r++) begin
            if (wb_valid_i && (wb_rd_i == 5'(r))) begin
                pend_eff[r] = 1'b0;
            end
        end
`endif
    end

    always_comb begin
        rs1_haz = 1'b0;
        rs2_haz = 1'b0;
        for (int unsigned r = 1; r < NREGS; r++) begin
            if ((dec_rs1_i == 5'(r)) && pend_eff[r]) begin
                rs1_haz = 1'b1;
            end
            if ((dec_rs2_i == 5'(r)) && pend_eff[r]) begin
                rs2_haz = 1'b1;
            end
        end
    end

    assign hazard     = rs1_haz | rs2_haz;
    assign if_ready_o = (state_q == ST_RUN) & ~hazard & ~flush_i
                        & (~ex_valid_q | ex_ready_i);
    assign accept     = if_valid_i & if_ready_o;
    assign load_set   = accept & (instr_i[6:0] == OPC_LOAD) & (dec_rd_i != 5'd0);

    // Clear is applied before set so a same-cycle set on the same register wins.
    always_comb begin
        pend_d = pend_q;
        for (int unsigned r = 1; r < NREGS; r++) begin
            if (wb_valid_i && (wb_rd_i == 5'(r))) begin
                pend_d[r] = 1'b0;
            end
            if (load_set && (dec_rd_i == 5'(r))) begin
                pend_d[r] = 1'b1;
            end
        end
    end

    always_comb begin
        ex_valid_d = ex_valid_q;
        instr_d    = instr_q;
        pc_d       = pc_q;
        rd_d       = rd_q;
        if (flush_i) begin
            ex_valid_d = 1'b0;
        end else if (accept && !dec_invalid_i) begin
            ex_valid_d = 1'b1;
            instr_d    = instr_i;
            pc_d       = pc_i;
            rd_d       = dec_rd_i;
        end else if (ex_ready_i) begin
            ex_valid_d = 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        trap_pc_d = trap_pc_q;
        case (state_q)
            ST_RUN: begin
                if (accept && dec_invalid_i) begin
                    state_d   = ST_TRAP;
                    trap_pc_d = pc_i;
                end
            end
            ST_TRAP: begin
                if (trap_ack_i) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
        if (flush_i) begin
            state_d = ST_RUN;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (if_valid_i && !if_ready_o && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            ex_valid_q  <= 1'b0;
            instr_q     <= '0;
            pc_q        <= '0;
            rd_q        <= '0;
            trap_pc_q   <= '0;
            stall_cnt_q <= '0;
            pend_q      <= '0;
        end else begin
            state_q     <= state_d;
            ex_valid_q  <= ex_valid_d;
            instr_q     <= instr_d;
            pc_q        <= pc_d;
            rd_q        <= rd_d;
            trap_pc_q   <= trap_pc_d;
            stall_cnt_q <= stall_cnt_d;
            pend_q      <= pend_d;
        end
    end

    assign ex_valid_o  = ex_valid_q;
    assign instr_o     = instr_q;
    assign pc_o        = pc_q;
    assign rd_o        = rd_q;
    assign trap_o      = (state_q == ST_TRAP);
    assign trap_pc_o   = trap_pc_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_id_stage_ctrl.sv
// Bench for id_stage_ctrl: directed vector table, hand sequences, random vs reference model.
module tb_id_stage_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        if_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic        inv;
    logic        ex_ready;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        flush;
    logic        trap_ack;

    logic        if_ready_o, ex_valid_o, trap_o;
    logic [31:0] instr_o, pc_o, trap_pc_o, stall_cnt_o;
    logic [4:0]  rd_o;

    logic        if_ready4, ex_valid4, trap4;
    logic [31:0] instr4, pc4, tpc4;
    logic [4:0]  rd4;
    logic [3:0]  cnt4;

    id_stage_ctrl #(.XLEN(32), .NREGS(32), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .if_valid_i(if_valid), .if_ready_o(if_ready_o),
        .instr_i(instr), .pc_i(pc), .dec_rs1_i(rs1), .dec_rs2_i(rs2), .dec_rd_i(rd),
        .dec_invalid_i(inv), .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready),
        .instr_o(instr_o), .pc_o(pc_o), .rd_o(rd_o), .wb_valid_i(wb_valid),
        .wb_rd_i(wb_rd), .flush_i(flush), .trap_o(trap_o), .trap_pc_o(trap_pc_o),
        .trap_ack_i(trap_ack), .stall_cnt_o(stall_cnt_o)
    );

    id_stage_ctrl #(.XLEN(32), .NREGS(32), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .if_valid_i(if_valid), .if_ready_o(if_ready4),
        .instr_i(instr), .pc_i(pc), .dec_rs1_i(rs1), .dec_rs2_i(rs2), .dec_rd_i(rd),
        .dec_invalid_i(inv), .ex_valid_o(ex_valid4), .ex_ready_i(ex_ready),
        .instr_o(instr4), .pc_o(pc4), .rd_o(rd4), .wb_valid_i(wb_valid),
        .wb_rd_i(wb_rd), .flush_i(flush), .trap_o(trap4), .trap_pc_o(tpc4),
        .trap_ack_i(trap_ack), .stall_cnt_o(cnt4)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: set of pending registers plus the architectural view of the stage.
    bit               m_pend[32];
    bit               m_v;
    logic [31:0]      m_instr, m_pc;
    logic [4:0]       m_rd;
    bit               m_trap;
    logic [31:0]      m_tpc;
    longint unsigned  m_cnt;
    bit               m_rdy;
    logic             obs_rdy;

    function automatic bit m_busy(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
`ifdef WB_FORWARD_EN
        if (wb_valid && wb_rd == r) return 1'b0;
`endif
        return m_pend[r];
    endfunction

    task automatic set_in(input logic v, input logic [31:0] ins, input logic [31:0] p,
                          input logic exr, input logic wbv, input logic [4:0] wbr,
                          input logic fl, input logic ak);
        if_valid = v;
        instr    = ins;
        pc       = p;
        rd       = ins[11:7];
        rs1      = ins[19:15];
        rs2      = ins[24:20];
        inv      = (ins == 32'hFFFF_FFFF);
        ex_ready = exr;
        wb_valid = wbv;
        wb_rd    = wbr;
        flush    = fl;
        trap_ack = ak;
    endtask

    task automatic step();
        bit acc;
        bit was_rst;
        @(negedge clk);
        m_rdy   = !m_trap && !m_busy(rs1) && !m_busy(rs2) && !flush && (!m_v || ex_ready);
        obs_rdy = if_ready_o;
        was_rst = rst;
        if (!rst) begin
            chk("if_ready", if_ready_o, m_rdy);
            chk("if_ready_c4", if_ready4, m_rdy);
        end
        @(posedge clk);
        if (rst) begin
            foreach (m_pend[i]) m_pend[i] = 1'b0;
            m_v = 0; m_instr = '0; m_pc = '0; m_rd = '0;
            m_trap = 0; m_tpc = '0; m_cnt = 0;
        end else begin
            acc = if_valid && m_rdy;
            if (if_valid && !m_rdy && m_cnt < 64'hFFFF_FFFF) m_cnt++;
            if (wb_valid) m_pend[wb_rd] = 1'b0;
            if (acc && instr[6:0] == 7'b0000011 && rd != 5'd0) m_pend[rd] = 1'b1;
            if (flush) begin
                m_v    = 0;
                m_trap = 0;
            end else begin
                if (m_trap && trap_ack) m_trap = 0;
                if (acc && !inv) begin
                    m_v = 1; m_instr = instr; m_pc = pc; m_rd = rd;
                end else if (ex_ready) begin
                    m_v = 0;
                end
                if (acc && inv) begin
                    m_trap = 1;
                    m_tpc  = pc;
                end
            end
        end
        #1;
        chk("ex_valid", ex_valid_o, m_v);
        chk("ex_valid_c4", ex_valid4, m_v);
        if (m_v) begin
            chk("instr_o", instr_o, m_instr);
            chk("pc_o", pc_o, m_pc);
            chk("rd_o", rd_o, m_rd);
            chk("pc_o_c4", pc4, m_pc);
            chk("instr_o_c4", instr4, m_instr);
            chk("rd_o_c4", rd4, m_rd);
        end
        if (was_rst) begin
            chk("rst_instr", instr_o, 0);
            chk("rst_pc", pc_o, 0);
            chk("rst_rd", rd_o, 0);
        end
        chk("trap_o", trap_o, m_trap);
        chk("trap_pc_o", trap_pc_o, m_tpc);
        chk("trap_o_c4", trap4, m_trap);
        chk("trap_pc_c4", tpc4, m_tpc);
        chk("stall_cnt", stall_cnt_o, m_cnt);
        chk("stall_cnt_c4", cnt4, (m_cnt > 15) ? 15 : m_cnt);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in(0, 32'h0000_0013, 0, 1, 0, 0, 0, 0);
        step();
        step();
        rst = 1'b0;
    endtask

    typedef struct {
        logic        v;
        logic [31:0] ins;
        logic [31:0] p;
        logic        exr;
        logic        ack;
        logic        e_rdy;
        logic        e_v;
        logic [31:0] e_ins;
        logic [31:0] e_pc;
        logic        e_trap;
        logic [31:0] e_tpc;
        int unsigned e_cnt;
    } vec_t;

    function automatic vec_t mk(logic v, logic [31:0] ins, logic [31:0] p, logic exr, logic ack,
                                logic e_rdy, logic e_v, logic [31:0] e_ins, logic [31:0] e_pc,
                                logic e_trap, logic [31:0] e_tpc, int unsigned e_cnt);
        vec_t t;
        t.v = v; t.ins = ins; t.p = p; t.exr = exr; t.ack = ack;
        t.e_rdy = e_rdy; t.e_v = e_v; t.e_ins = e_ins; t.e_pc = e_pc;
        t.e_trap = e_trap; t.e_tpc = e_tpc; t.e_cnt = e_cnt;
        return t;
    endfunction

    localparam logic [31:0] ADDI = 32'h0050_0093;
    localparam logic [31:0] ADD  = 32'h0010_8133;
    localparam logic [31:0] IA   = 32'h0020_8193;
    localparam logic [31:0] IB   = 32'h0031_0233;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] ILL  = 32'hFFFF_FFFF;

    vec_t vecs[13];

    initial begin
        logic [31:0] ri;
        logic [4:0]  f_rd, f_rs1, f_rs2;
        int unsigned k;

        vecs[0]  = mk(1, ADDI, 32'h00, 1, 0, 1, 1, ADDI, 32'h00, 0, 32'h00, 0);
        vecs[1]  = mk(1, ADD,  32'h04, 1, 0, 1, 1, ADD,  32'h04, 0, 32'h00, 0);
        vecs[2]  = mk(0, NOP,  32'h00, 1, 0, 1, 0, NOP,  32'h00, 0, 32'h00, 0);
        vecs[3]  = mk(1, IA,   32'h08, 1, 0, 1, 1, IA,   32'h08, 0, 32'h00, 0);
        vecs[4]  = mk(1, IB,   32'h0C, 0, 0, 0, 1, IA,   32'h08, 0, 32'h00, 1);
        vecs[5]  = mk(1, IB,   32'h0C, 0, 0, 0, 1, IA,   32'h08, 0, 32'h00, 2);
        vecs[6]  = mk(1, IB,   32'h0C, 0, 0, 0, 1, IA,   32'h08, 0, 32'h00, 3);
        vecs[7]  = mk(1, IB,   32'h0C, 1, 0, 1, 1, IB,   32'h0C, 0, 32'h00, 3);
        vecs[8]  = mk(1, ILL,  32'h40, 1, 0, 1, 0, NOP,  32'h00, 1, 32'h40, 3);
        vecs[9]  = mk(1, NOP,  32'h44, 1, 0, 0, 0, NOP,  32'h00, 1, 32'h40, 4);
        vecs[10] = mk(1, NOP,  32'h44, 1, 1, 0, 0, NOP,  32'h00, 0, 32'h40, 5);
        vecs[11] = mk(1, NOP,  32'h44, 1, 0, 1, 1, NOP,  32'h44, 0, 32'h40, 5);
        vecs[12] = mk(0, NOP,  32'h00, 1, 1, 1, 0, NOP,  32'h00, 0, 32'h40, 5);

        do_reset();
        chk("reset_valid", ex_valid_o, 0);
        chk("reset_trap", trap_o, 0);
        chk("reset_cnt", stall_cnt_o, 0);

        for (int i = 0; i < 13; i++) begin
            set_in(vecs[i].v, vecs[i].ins, vecs[i].p, vecs[i].exr, 0, 0, 0, vecs[i].ack);
            step();
            chk($sformatf("vec%0d_rdy", i), obs_rdy, vecs[i].e_rdy);
            chk($sformatf("vec%0d_valid", i), ex_valid_o, vecs[i].e_v);
            if (vecs[i].e_v) begin
                chk($sformatf("vec%0d_pc", i), pc_o, vecs[i].e_pc);
                chk($sformatf("vec%0d_instr", i), instr_o, vecs[i].e_ins);
            end
            chk($sformatf("vec%0d_trap", i), trap_o, vecs[i].e_trap);
            chk($sformatf("vec%0d_tpc", i), trap_pc_o, vecs[i].e_tpc);
            chk($sformatf("vec%0d_cnt", i), stall_cnt_o, vecs[i].e_cnt);
        end

        // Load-use: lw x3 then add x4,x3,x3
        do_reset();
        set_in(1, 32'h0000_2183, 32'h100, 1, 0, 0, 0, 0);
        step();
        chk("lu_lw_rdy", obs_rdy, 1);
        set_in(1, 32'h0031_8233, 32'h104, 1, 0, 0, 0, 0);
        step();
        chk("lu_stall1", obs_rdy, 0);
        step();
        chk("lu_stall2", obs_rdy, 0);
        set_in(1, 32'h0031_8233, 32'h104, 1, 1, 5'd3, 0, 0);
        step();
`ifdef WB_FORWARD_EN
        chk("lu_wb_rdy", obs_rdy, 1);
        chk("lu_cnt", stall_cnt_o, 2);
`else
        chk("lu_wb_rdy", obs_rdy, 0);
        set_in(1, 32'h0031_8233, 32'h104, 1, 0, 0, 0, 0);
        step();
        chk("lu_after_rdy", obs_rdy, 1);
        chk("lu_cnt", stall_cnt_o, 3);
`endif
        chk("lu_issue_pc", pc_o, 32'h104);
        chk("lu_issue_v", ex_valid_o, 1);

        // Flush with a pending load on x5
        do_reset();
        set_in(1, 32'h0000_2283, 32'h200, 0, 0, 0, 0, 0);
        step();
        chk("fl_lw_v", ex_valid_o, 1);
        set_in(1, 32'h0002_8333, 32'h204, 0, 0, 0, 1, 1);
        step();
        chk("fl_rdy", obs_rdy, 0);
        chk("fl_valid", ex_valid_o, 0);
        set_in(1, 32'h0002_8333, 32'h204, 1, 0, 0, 0, 0);
        step();
        chk("fl_x5_stall1", obs_rdy, 0);
        step();
        chk("fl_x5_stall2", obs_rdy, 0);
        set_in(1, 32'h0002_8333, 32'h204, 1, 1, 5'd5, 0, 0);
        step();
`ifdef WB_FORWARD_EN
        chk("fl_wb_rdy", obs_rdy, 1);
`else
        chk("fl_wb_rdy", obs_rdy, 0);
        set_in(1, 32'h0002_8333, 32'h204, 1, 0, 0, 0, 0);
        step();
        chk("fl_after_rdy", obs_rdy, 1);
`endif
        chk("fl_issue_pc", pc_o, 32'h204);

        // Counter saturation on the 4-bit instance
        do_reset();
        set_in(1, NOP, 32'h300, 1, 0, 0, 0, 0);
        step();
        set_in(1, NOP, 32'h304, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) step();
        chk("sat_cnt32", stall_cnt_o, 20);
        chk("sat_cnt4", cnt4, 4'hF);
        step();
        chk("sat_cnt4_hold", cnt4, 4'hF);
        chk("sat_pc_hold", pc_o, 32'h300);
        set_in(1, 32'h0000_2003, 32'h308, 1, 0, 0, 0, 0);
        step();
        set_in(1, 32'h0000_00B3, 32'h30C, 1, 0, 0, 0, 0);
        step();
        chk("lw_x0_no_stall", obs_rdy, 1);

        // Random traffic against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rst   = ($urandom_range(99) == 0);
            f_rd  = 5'($urandom_range(7));
            f_rs1 = 5'($urandom_range(7));
            f_rs2 = 5'($urandom_range(7));
            k     = $urandom_range(9);
            if (k < 3)
                ri = {12'h000, f_rs1, 3'b010, f_rd, 7'b0000011};
            else if (k == 9 && $urandom_range(3) == 0)
                ri = ILL;
            else
                ri = {7'h00, f_rs2, f_rs1, 3'b000, f_rd, 7'b0110011};
            set_in($urandom_range(3) != 0, ri, {$urandom_range(32'h3FFF_FFFF), 2'b00},
                   $urandom_range(3) != 0, $urandom_range(3) == 0,
                   5'($urandom_range(7)), $urandom_range(19) == 0, $urandom_range(3) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
